cla_result_stage: RTL
=====================

# cla_result_stage

Registered result and flag stage directly downstream of the 16-bit carry-lookahead add/subtract unit. It captures the adder's sum and carry-out together with the operand sign bits and operation select. It derives N/Z/C/V condition flags and buffers results in a 2-entry FIFO behind a valid/ready handshake. It also keeps a sticky overflow flag and a saturating overflow-event counter for the control block.

## Interface
Parameters:
- W, 16, datapath width; must match the adder width.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream adder result is valid this cycle.
- in_ready  out  1  stage can accept; equals NOT full.
- in_sub  in  1  operation select, i.e. the CI driven into the adder (1 = A − B).
- in_a_msb  in  1  A[W-1] as presented to the adder.
- in_b_msb  in  1  original, un-inverted B[W-1].
- in_s  in  W  adder sum S.
- in_co  in  1  adder carry-out CO.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head entry.
- out_s  out  W  head entry sum.
- out_flags  out  4  head entry flags {N, Z, C, V}.
- sticky_v  out  1  set by any accepted overflow; held until cleared.
- clr_sticky  in  1  synchronous clear of sticky_v and ovf_count.
- ovf_count  out  CNT_W  number of accepted overflowing results, saturating.

## Operation
- Transfer rules:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready depends only on FIFO occupancy, never on out_ready.
- Flags are computed combinationally from the inputs at push and stored with the entry:
  - N = in_s[W-1].
  - Z = (in_s == 0).
  - C = in_co when in_sub=0 (carry out). C = ~in_co when in_sub=1 (borrow).
  - V for add (in_sub=0) = (in_a_msb == in_b_msb) & (in_s[W-1] != in_a_msb).
  - V for subtract (in_sub=1) = (in_a_msb != in_b_msb) & (in_s[W-1] != in_a_msb).
- FIFO:
  - Two entries of {s, flags}, with 1-bit read and write pointers and a 2-bit count.
  - Pointers wrap 1→0.
  - Order is strictly first-in first-out; no entry is dropped or duplicated.
  - Occupancy states are EMPTY (0), ONE (1) and FULL (2):
    - EMPTY: push → ONE.
    - ONE: push only → FULL; pop only → EMPTY; push and pop together → ONE, with the pointers advancing.
    - FULL: pop → ONE. Push is impossible because in_ready=0.
- Sticky overflow and counter:
  - A push with V=1 sets sticky_v and increments ovf_count.
  - ovf_count saturates at 2^CNT_W−1 and never wraps.
  - clr_sticky together with a V=1 push: the result is sticky_v=1 and ovf_count=1 (the set wins over the clear).
  - clr_sticky alone: the result is 0 and 0.
  - Popping has no effect on sticky_v or ovf_count.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, out_valid=0, in_ready=1, out_s=0, out_flags=0, sticky_v=0, ovf_count=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- Latency:
  - A push in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty.
  - Otherwise the entry appears after all older entries have popped.
- Outputs:
  - out_s and out_flags are driven from the head entry (registered storage); there is no combinational path from in_* to out_*.
  - out_s and out_flags hold stable while out_valid=1 and out_ready=0.
- Throughput: one result per cycle sustained when out_ready is held high.
- Update timing: sticky_v and ovf_count update on the clock edge of the push and are visible the next cycle.

## Test plan
- Add overflow: in_sub=0, A=0x7FFF, B=0x0001, in_s=0x8000, in_co=0 → out_s=0x8000, flags N=1 Z=0 C=0 V=1. Next cycle sticky_v=1, ovf_count=1.
- Equal subtract: in_sub=1, A=0x0005, B=0x0005, in_s=0x0000, in_co=1 → flags N=0 Z=1 C=0 V=0.
- Borrow: in_sub=1, A=0x0000, B=0x0001, in_s=0xFFFF, in_co=0 → N=1 Z=0 C=1 V=0. Then subtract overflow: A=0x8000, B=0x0001, in_s=0x7FFF, in_co=1 → V=1, C=0.
- Backpressure: hold out_ready=0 and push 3 back-to-back.
  - in_ready drops after 2 pushes, and the third is held by upstream.
  - Raise out_ready: entries exit in order, and the third is accepted the cycle after the first pop.
- Counter and clear:
  - Push 300 V=1 results → ovf_count=255 (saturated).
  - clr_sticky coincident with a V=1 push → sticky_v=1, ovf_count=1.
  - clr_sticky alone → 0, 0.
- Reset mid-operation: with FIFO FULL, drop rst_n asynchronously (not on a clock edge) → out_valid=0 and in_ready=1 immediately, and all outputs are at their reset values.

Source files
------------

// File: rtl/cla_result_stage.sv
// Result/flag stage behind the 16-bit CLA add/subtract unit: derives N/Z/C/V,
// buffers {sum, flags} in a 2-entry FIFO, tracks sticky overflow and an event count.
//
// FIFO occupancy FSM
//   state | meaning
//   EMPTY | no buffered result, out_valid=0, in_ready=1
//   ONE   | one result at the head, out_valid=1, in_ready=1
//   FULL  | two results buffered, out_valid=1, in_ready=0
module cla_result_stage #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic [W-1:0]     in_s,
  input  logic             in_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic [3:0]       out_flags,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_t       count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;
  logic       push_v;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       sign_flip;
  logic [3:0] flags_in;

  logic [W-1:0] mem_s [2];
  logic [3:0]   mem_f [2];

  // B arrives un-inverted, so subtract overflow needs differing operand signs.
  assign sign_flip = (in_s[W-1] != in_a_msb);
  assign flag_n    = in_s[W-1];
  assign flag_z    = (in_s == '0);
  assign flag_c    = in_sub ? ~in_co : in_co;
  assign flag_v    = in_sub ? ((in_a_msb != in_b_msb) & sign_flip)
                            : ((in_a_msb == in_b_msb) & sign_flip);
  assign flags_in  = {flag_n, flag_z, flag_c, flag_v};

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign push_v = push & flag_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case (count)
        EMPTY: begin
          if (push) begin
            count     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            count    <= FULL;
            in_ready <= 1'b0;
          end else if (pop && !push) begin
            count     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            count    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          count     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_s[i] <= '0;
        mem_f[i] <= '0;
      end
    end else if (push) begin
      mem_s[wr_ptr] <= in_s;
      mem_f[wr_ptr] <= flags_in;
    end
  end

  assign out_s     = mem_s[rd_ptr];
  assign out_flags = mem_f[rd_ptr];

  // An overflowing push beats a coincident clear: the new event is counted as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else if (push_v) begin
      sticky_v <= 1'b1;
      if (clr_sticky)
        ovf_count <= CNT_W'(1);
      else if (ovf_count != CNT_MAX)
        ovf_count <= ovf_count + CNT_W'(1);
    end else if (clr_sticky) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end
  end

endmodule
